// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Execute-stage branch resolver: evaluates the branch condition from the ALU
// zero/sign flags, computes the target PC, and drives a one-cycle redirect
// followed by a fixed-length flush. EX is back-pressured while a flush runs.
// Optional feature macro: BRANCH_STATS_EN (saturating branch/taken counters).
module branch_resolve_unit #(
    parameter int FLUSH_CYCLES = 2   // 1..15, includes the redirect cycle
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_is_branch,
    input  logic [1:0]  ex_br_type,
    input  logic        ex_zero,
    input  logic        ex_neg,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [15:0] br_count,
    output logic [15:0] taken_count
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REDIRECT = 2'd1,
        S_FLUSH    = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic        w_accept;
    logic        w_br_accept;
    logic        w_cond;
    logic        w_taken_accept;
    logic [31:0] w_target;

    // Handshake: the unit only listens to EX while idle.
    assign ex_ready       = (r_state == S_IDLE);
    assign w_accept       = ex_valid & ex_ready;
    assign w_br_accept    = w_accept & ex_is_branch;
    assign w_taken_accept = w_br_accept & w_cond;

    // Word offset shifted to bytes; upper immediate bits fall off the top.
    assign w_target = ex_pc + 32'd4 + (ex_imm << 2);

    // Branch condition from the ALU flags.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        w_cond = 1'b0;
        case (ex_br_type)
            2'b00:   w_cond = ex_zero;
            2'b01:   w_cond = ~ex_zero;
            2'b10:   w_cond = ex_zero | ex_neg;
            2'b11:   w_cond = ~ex_zero & ~ex_neg;
            default: w_cond = 1'b0;
        endcase
    end

    // Next-state and flush-counter logic.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_taken_accept) begin
                    w_state_next = S_REDIRECT;
                    w_cnt_next   = FLUSH_LOAD;
                end
            end
            S_REDIRECT: begin
                w_state_next = (r_cnt != 4'd0) ? S_FLUSH : S_IDLE;
            end
            S_FLUSH: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // State and flush-counter registers; reset abandons any pending flush.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Target latch: holds the last taken target until the next redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_pc <= 32'd0;
        end else if (w_taken_accept) begin
            redirect_pc <= w_target;
        end
    end

    // Outputs decode straight from the state register, so they are glitch-free
    // and drop as soon as reset forces the state back to idle.
    assign redirect_valid = (r_state == S_REDIRECT);
    assign flush          = (r_state != S_IDLE);

`ifdef BRANCH_STATS_EN
    logic [15:0] r_br_count;
    logic [15:0] r_taken_count;

    // Saturating statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_br_count    <= 16'd0;
            r_taken_count <= 16'd0;
        end else begin
            if (w_br_accept && (r_br_count != 16'hFFFF)) begin
                r_br_count <= r_br_count + 16'd1;
            end
            if (w_taken_accept && (r_taken_count != 16'hFFFF)) begin
                r_taken_count <= r_taken_count + 16'd1;
            end
        end
    end

    assign br_count    = r_br_count;
    assign taken_count = r_taken_count;
`else
    assign br_count    = 16'd0;
    assign taken_count = 16'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed vectors, a cycle-numbered
// reference model, a per-cycle compare process and literal spot checks.
`timescale 1ns/1ps
module tb_branch_resolve_unit;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic        ex_is_branch = 1'b0;
    logic [1:0]  ex_br_type = 2'b00;
    logic        ex_zero = 1'b0;
    logic        ex_neg = 1'b0;
    logic [31:0] ex_pc = 32'd0;
    logic [31:0] ex_imm = 32'd0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [15:0] br_count;
    logic [15:0] taken_count;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    branch_resolve_unit #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_is_branch(ex_is_branch), .ex_br_type(ex_br_type),
        .ex_zero(ex_zero), .ex_neg(ex_neg),
        .ex_pc(ex_pc), .ex_imm(ex_imm),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush(flush), .br_count(br_count), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (cycle-numbered) ----------------
    // Cycle k lies between rising edges k and k+1. A taken branch accepted at
    // the edge that starts cycle k+1 redirects in k+1 and keeps EX stalled
    // through cycle k+FC.
    int          cyc = 0;
    int          redirect_cyc = -1;
    int          busy_until = -1;
    logic [31:0] m_pc = 32'd0;
    int          m_br = 0;
    int          m_taken = 0;

    function automatic bit spec_taken(input logic [1:0] t, input logic z, input logic n);
        case (t)
            2'b00:   return z == 1'b1;
            2'b01:   return z == 1'b0;
            2'b10:   return (z == 1'b1) || (n == 1'b1);
            default: return (z == 1'b0) && (n == 1'b0);
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_cyc = -1;
            busy_until   = -1;
            m_pc         = 32'd0;
            m_br         = 0;
            m_taken      = 0;
        end else begin
            if ((ex_valid === 1'b1) && (cyc > busy_until) && (ex_is_branch === 1'b1)) begin
                m_br = (m_br < 65535) ? m_br + 1 : 65535;
                if (spec_taken(ex_br_type, ex_zero, ex_neg)) begin
                    m_taken      = (m_taken < 65535) ? m_taken + 1 : 65535;
                    redirect_cyc = cyc + 1;
                    busy_until   = cyc + FC;
                    m_pc         = ex_pc + 32'd4 + ex_imm * 32'd4;
                end
            end
            cyc = cyc + 1;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("ex_ready",       {31'd0, ex_ready},       {31'd0, cyc > busy_until});
            check("flush",          {31'd0, flush},          {31'd0, cyc <= busy_until});
            check("redirect_valid", {31'd0, redirect_valid}, {31'd0, cyc == redirect_cyc});
            check("redirect_pc",    redirect_pc,             m_pc);
`ifdef BRANCH_STATS_EN
            check("br_count",    {16'd0, br_count},    m_br);
            check("taken_count", {16'd0, taken_count}, m_taken);
`else
            check("br_count",    {16'd0, br_count},    32'd0);
            check("taken_count", {16'd0, taken_count}, 32'd0);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic br, input logic [1:0] t, input logic z, input logic n,
                           input logic [31:0] pc, input logic [31:0] imm);
        ex_valid     = 1'b1;
        ex_is_branch = br;
        ex_br_type   = t;
        ex_zero      = z;
        ex_neg       = n;
        ex_pc        = pc;
        ex_imm       = imm;
    endtask

    // Hold an instruction until it is accepted, bounded by a cycle budget.
    task automatic issue(input logic br, input logic [1:0] t, input logic z, input logic n,
                         input logic [31:0] pc, input logic [31:0] imm);
        bit done;
        done = 1'b0;
        present(br, t, z, n, pc, imm);
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (ex_ready) begin
                tick();
                done = 1'b1;
            end
        end
        ex_valid = 1'b0;
        if (!done) check("issue_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int pulses;

    initial begin
        // Reset then idle.
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, ex_ready}, 32'd1);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_rv",    {31'd0, redirect_valid}, 32'd0);
        check("rst_pc",    redirect_pc, 32'd0);

        // BEQ taken, pc=0x100 imm=3 -> 0x110.
        tick();
        present(1'b1, 2'b00, 1'b1, 1'b0, 32'h100, 32'd3);
        tick();
        ex_valid = 1'b0;
        @(negedge clk);
        check("beq_rv_n1",    {31'd0, redirect_valid}, 32'd1);
        check("beq_flush_n1", {31'd0, flush}, 32'd1);
        check("beq_ready_n1", {31'd0, ex_ready}, 32'd0);
        check("beq_pc",       redirect_pc, 32'h110);
        tick();
        @(negedge clk);
        check("beq_rv_n2",    {31'd0, redirect_valid}, 32'd0);
        check("beq_flush_n2", {31'd0, flush}, 32'd1);
        check("beq_ready_n2", {31'd0, ex_ready}, 32'd0);
        tick();
        @(negedge clk);
        check("beq_ready_n3", {31'd0, ex_ready}, 32'd1);
        check("beq_flush_n3", {31'd0, flush}, 32'd0);

        // BNE not taken (no bubble), then BGTZ with wrap-around target.
        tick();
        present(1'b1, 2'b01, 1'b1, 1'b0, 32'h500, 32'd7);
        tick();
        present(1'b1, 2'b11, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'd0);
        @(negedge clk);
        check("bne_nobubble_ready", {31'd0, ex_ready}, 32'd1);
        check("bne_no_flush",       {31'd0, flush}, 32'd0);
        tick();
        ex_valid = 1'b0;
        @(negedge clk);
        check("bgtz_rv",   {31'd0, redirect_valid}, 32'd1);
        check("bgtz_wrap", redirect_pc, 32'h0000_0000);
        repeat (FC) tick();

        // X on type/flags while ex_valid=0 must not disturb anything.
        ex_is_branch = 1'b1;
        ex_br_type   = 2'bxx;
        ex_zero      = 1'bx;
        ex_neg       = 1'bx;
        repeat (3) tick();
        ex_is_branch = 1'b0;
        ex_br_type   = 2'b00;
        ex_zero      = 1'b0;
        ex_neg       = 1'b0;

        // BLEZ held through a flush is taken exactly once.
        present(1'b1, 2'b00, 1'b1, 1'b0, 32'h200, 32'hFFFF_FFFF);
        tick();
        present(1'b1, 2'b10, 1'b0, 1'b1, 32'h300, 32'd2);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pulses += int'(redirect_valid);
            tick();
            if (i == 2) ex_valid = 1'b0;
        end
        check("blez_pulses", pulses, 32'd2);
        check("blez_pc",     redirect_pc, 32'h30C);

        // Reset in the middle of FLUSH.
        present(1'b1, 2'b00, 1'b1, 1'b0, 32'h400, 32'd0);
        tick();
        ex_valid = 1'b0;
        tick();
        #1;
        check("pre_rst_flush", {31'd0, flush}, 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_flush", {31'd0, flush}, 32'd0);
        check("async_rst_ready", {31'd0, ex_ready}, 32'd1);
        check("async_rst_rv",    {31'd0, redirect_valid}, 32'd0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pulses += int'(redirect_valid | flush);
        end
        check("post_rst_quiet", pulses, 32'd0);

`ifdef BRANCH_STATS_EN
        // Fresh counters: 5 branches, 3 taken, plus one non-branch.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        issue(1'b1, 2'b00, 1'b1, 1'b0, 32'h1000, 32'd1);   // taken
        issue(1'b1, 2'b01, 1'b1, 1'b0, 32'h1004, 32'd1);   // not taken
        issue(1'b0, 2'b00, 1'b1, 1'b0, 32'h1008, 32'd1);   // non-branch
        issue(1'b1, 2'b10, 1'b0, 1'b1, 32'h100C, 32'd4);   // taken
        issue(1'b1, 2'b11, 1'b1, 1'b0, 32'h1010, 32'd1);   // not taken
        issue(1'b1, 2'b01, 1'b0, 1'b0, 32'h1014, 32'd2);   // taken
        repeat (FC + 1) tick();
        @(negedge clk);
        check("stats_br5",    {16'd0, br_count},    32'd5);
        check("stats_taken3", {16'd0, taken_count}, 32'd3);
        tick();
        present(1'b1, 2'b01, 1'b1, 1'b0, 32'h2000, 32'd0);
        repeat (70000) tick();
        ex_valid = 1'b0;
        @(negedge clk);
        check("stats_br_sat",  {16'd0, br_count},    32'h0000_FFFF);
        check("stats_taken_k", {16'd0, taken_count}, 32'd3);
`else
        issue(1'b1, 2'b00, 1'b1, 1'b0, 32'h1000, 32'd1);
        issue(1'b1, 2'b01, 1'b1, 1'b0, 32'h1004, 32'd1);
        repeat (FC + 1) tick();
        @(negedge clk);
        check("nostats_br0",    {16'd0, br_count},    32'd0);
        check("nostats_taken0", {16'd0, taken_count}, 32'd0);
`endif

        tick();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
